// File: rtl/cam_ctrl_pkg.sv
// cam_ctrl_pkg
//   Shared definitions for the CAM access controller: CAM geometry, the
//   reserved empty-entry marker, command op encodings and the controller
//   state enum.
package cam_ctrl_pkg;

    localparam int ENTRIES = 16;
    localparam int KEY_W   = 8;
    localparam int IDX_W   = 4;
    localparam int CNT_W   = 5;

    // Written into free entries; never accepted as a command key.
    localparam logic [KEY_W-1:0] EMPTY_KEY = 8'hFF;

    localparam logic [1:0] OP_LOOKUP = 2'b00;
    localparam logic [1:0] OP_INSERT = 2'b01;
    localparam logic [1:0] OP_DELETE = 2'b10;

    typedef enum logic [2:0] {
        ST_INIT   = 3'd0,
        ST_IDLE   = 3'd1,
        ST_LOOKUP = 3'd2,
        ST_CHECK  = 3'd3,
        ST_WRITE  = 3'd4,
        ST_RESP   = 3'd5
    } state_e;

endpackage

// File: rtl/cam_free_enc.sv
// cam_free_enc
//   Lowest-zero priority encoder over the entry valid bits. Picks the free
//   slot an insert will allocate.
//   Ports:
//     valid_i    : per-entry occupancy
//     free_idx_o : lowest index whose valid bit is 0 (0 when full)
//     full_o     : every entry is occupied
module cam_free_enc
    import cam_ctrl_pkg::*;
(
    input  logic [ENTRIES-1:0] valid_i,
    output logic [IDX_W-1:0]   free_idx_o,
    output logic               full_o
);

    always_comb begin
        free_idx_o = '0;
        full_o     = &valid_i;
        // Scan downward so the lowest free index is the last one assigned.
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!valid_i[i]) begin
                free_idx_o = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/cam_access_ctrl.sv
// cam_access_ctrl
//   Owns an external 16x8 CAM and shares it between two requesters. After
//   reset it sweeps EMPTY_KEY into every entry, then serves one command at a
//   time (lookup / insert / delete) with round-robin arbitration, tracking
//   occupancy and allocating the lowest free slot on insert.
//   Handshake: requester i transfers a command in a cycle where
//   req_valid[i] & req_ready[i]; req_valid is held until then. Responses are
//   a single rsp_valid pulse with no backpressure.
//   Ports:
//     req_valid/req_ready   : per-requester command handshake
//     req{0,1}_op/_key      : command op and key
//     rsp_*                 : registered response (id, hit, index, err)
//     cam_wen/ren/din/addr  : registered CAM control pins
//     cam_dout/cam_hit      : CAM search result (registered inside the CAM)
//     count                 : number of occupied entries
//     init_done             : clearing sweep finished
//     dbg_state_o           : current FSM state
module cam_access_ctrl
    import cam_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [1:0]        req0_op,
    input  logic [KEY_W-1:0]  req0_key,
    input  logic [1:0]        req1_op,
    input  logic [KEY_W-1:0]  req1_key,
    output logic              rsp_valid,
    output logic              rsp_id,
    output logic              rsp_hit,
    output logic [IDX_W-1:0]  rsp_index,
    output logic              rsp_err,
    output logic              cam_wen,
    output logic              cam_ren,
    output logic [KEY_W-1:0]  cam_din,
    output logic [IDX_W-1:0]  cam_addr,
    input  logic [IDX_W-1:0]  cam_dout,
    input  logic              cam_hit,
    output logic [CNT_W-1:0]  count,
    output logic              init_done,
    output state_e            dbg_state_o
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   sweep_q, sweep_d;
    logic               last_q, last_d;
    logic               cmd_id_q, cmd_id_d;
    logic [1:0]         cmd_op_q, cmd_op_d;
    logic [KEY_W-1:0]   cmd_key_q, cmd_key_d;
    logic               res_hit_q, res_hit_d;
    logic [IDX_W-1:0]   res_idx_q, res_idx_d;
    logic               res_err_q, res_err_d;
    logic               wr_set_q, wr_set_d;
    logic [IDX_W-1:0]   wr_idx_q, wr_idx_d;
    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               init_done_q, init_done_d;

    logic               rsp_valid_q, rsp_valid_d;
    logic               rsp_id_q, rsp_id_d;
    logic               rsp_hit_q, rsp_hit_d;
    logic [IDX_W-1:0]   rsp_idx_q, rsp_idx_d;
    logic               rsp_err_q, rsp_err_d;
    logic               cam_wen_q, cam_wen_d;
    logic               cam_ren_q, cam_ren_d;
    logic [KEY_W-1:0]   cam_din_q, cam_din_d;
    logic [IDX_W-1:0]   cam_addr_q, cam_addr_d;

    logic               grant;
    logic [1:0]         sel_op;
    logic [KEY_W-1:0]   sel_key;
    logic [IDX_W-1:0]   free_idx;
    logic               full;

    cam_free_enc u_free_enc (
        .valid_i    (valid_q),
        .free_idx_o (free_idx),
        .full_o     (full)
    );

    // With both requesters valid, grant the one not served last; last_q
    // resets to 1 so requester 0 wins the first contention.
    assign grant   = (&req_valid) ? ~last_q : req_valid[1];
    assign sel_op  = grant ? req1_op  : req0_op;
    assign sel_key = grant ? req1_key : req0_key;

    always_comb begin
        state_d     = state_q;
        sweep_d     = sweep_q;
        last_d      = last_q;
        cmd_id_d    = cmd_id_q;
        cmd_op_d    = cmd_op_q;
        cmd_key_d   = cmd_key_q;
        res_hit_d   = res_hit_q;
        res_idx_d   = res_idx_q;
        res_err_d   = res_err_q;
        wr_set_d    = wr_set_q;
        wr_idx_d    = wr_idx_q;
        valid_d     = valid_q;
        count_d     = count_q;
        init_done_d = init_done_q;
        cam_wen_d   = 1'b0;
        cam_ren_d   = 1'b0;
        cam_din_d   = cam_din_q;
        cam_addr_d  = cam_addr_q;
        req_ready   = 2'b00;

        case (state_q)
            ST_INIT: begin
                if (sweep_q < CNT_W'(ENTRIES)) begin
                    cam_wen_d  = 1'b1;
                    cam_din_d  = EMPTY_KEY;
                    cam_addr_d = sweep_q[IDX_W-1:0];
                    sweep_d    = sweep_q + 5'd1;
                end else begin
                    state_d     = ST_IDLE;
                    init_done_d = 1'b1;
                end
            end
            ST_IDLE: begin
                // CAM enables stay low here so cam_hit is cleared before the
                // next search.
                if (req_valid != 2'b00) begin
                    req_ready[grant] = 1'b1;
                    last_d    = grant;
                    cmd_id_d  = grant;
                    cmd_op_d  = sel_op;
                    cmd_key_d = sel_key;
                    res_hit_d = 1'b0;
                    res_idx_d = '0;
                    if (sel_op == 2'b11 || sel_key == EMPTY_KEY) begin
                        res_err_d = 1'b1;
                        state_d   = ST_RESP;
                    end else begin
                        res_err_d = 1'b0;
                        cam_ren_d = 1'b1;
                        cam_din_d = sel_key;
                        state_d   = ST_LOOKUP;
                    end
                end
            end
            ST_LOOKUP: begin
                state_d = ST_CHECK;
            end
            ST_CHECK: begin
                res_hit_d = cam_hit;
                res_idx_d = cam_hit ? cam_dout : '0;
                res_err_d = 1'b0;
                state_d   = ST_RESP;
                if (cmd_op_q == OP_INSERT && !cam_hit) begin
                    if (full) begin
                        res_err_d = 1'b1;
                    end else begin
                        res_idx_d  = free_idx;
                        wr_set_d   = 1'b1;
                        wr_idx_d   = free_idx;
                        cam_wen_d  = 1'b1;
                        cam_addr_d = free_idx;
                        cam_din_d  = cmd_key_q;
                        state_d    = ST_WRITE;
                    end
                end else if (cmd_op_q == OP_DELETE && cam_hit) begin
                    wr_set_d   = 1'b0;
                    wr_idx_d   = cam_dout;
                    cam_wen_d  = 1'b1;
                    cam_addr_d = cam_dout;
                    cam_din_d  = EMPTY_KEY;
                    state_d    = ST_WRITE;
                end
            end
            ST_WRITE: begin
                valid_d[wr_idx_q] = wr_set_q;
                count_d = wr_set_q ? count_q + 5'd1 : count_q - 5'd1;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Response registers load on entry to RESP so rsp_* are valid
        // together with the pulse.
        rsp_valid_d = (state_d == ST_RESP);
        rsp_id_d    = rsp_valid_d ? cmd_id_d  : rsp_id_q;
        rsp_hit_d   = rsp_valid_d ? res_hit_d : rsp_hit_q;
        rsp_idx_d   = rsp_valid_d ? res_idx_d : rsp_idx_q;
        rsp_err_d   = rsp_valid_d ? res_err_d : rsp_err_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_INIT;
            sweep_q     <= '0;
            last_q      <= 1'b1;
            cmd_id_q    <= 1'b0;
            cmd_op_q    <= 2'b00;
            cmd_key_q   <= '0;
            res_hit_q   <= 1'b0;
            res_idx_q   <= '0;
            res_err_q   <= 1'b0;
            wr_set_q    <= 1'b0;
            wr_idx_q    <= '0;
            valid_q     <= '0;
            count_q     <= '0;
            init_done_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_hit_q   <= 1'b0;
            rsp_idx_q   <= '0;
            rsp_err_q   <= 1'b0;
            cam_wen_q   <= 1'b0;
            cam_ren_q   <= 1'b0;
            cam_din_q   <= '0;
            cam_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            sweep_q     <= sweep_d;
            last_q      <= last_d;
            cmd_id_q    <= cmd_id_d;
            cmd_op_q    <= cmd_op_d;
            cmd_key_q   <= cmd_key_d;
            res_hit_q   <= res_hit_d;
            res_idx_q   <= res_idx_d;
            res_err_q   <= res_err_d;
            wr_set_q    <= wr_set_d;
            wr_idx_q    <= wr_idx_d;
            valid_q     <= valid_d;
            count_q     <= count_d;
            init_done_q <= init_done_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_hit_q   <= rsp_hit_d;
            rsp_idx_q   <= rsp_idx_d;
            rsp_err_q   <= rsp_err_d;
            cam_wen_q   <= cam_wen_d;
            cam_ren_q   <= cam_ren_d;
            cam_din_q   <= cam_din_d;
            cam_addr_q  <= cam_addr_d;
        end
    end

    assign rsp_valid   = rsp_valid_q;
    assign rsp_id      = rsp_id_q;
    assign rsp_hit     = rsp_hit_q;
    assign rsp_index   = rsp_idx_q;
    assign rsp_err     = rsp_err_q;
    assign cam_wen     = cam_wen_q;
    assign cam_ren     = cam_ren_q;
    assign cam_din     = cam_din_q;
    assign cam_addr    = cam_addr_q;
    assign count       = count_q;
    assign init_done   = init_done_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_cam_access_ctrl.sv
module tb_cam_access_ctrl;
    import cam_ctrl_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] req_valid = 2'b00;
    logic [1:0] req_ready;
    logic [1:0] req0_op = 2'b00, req1_op = 2'b00;
    logic [7:0] req0_key = 8'h00, req1_key = 8'h00;
    logic       rsp_valid, rsp_id, rsp_hit, rsp_err;
    logic [3:0] rsp_index;
    logic       cam_wen, cam_ren;
    logic [7:0] cam_din;
    logic [3:0] cam_addr;
    logic [3:0] cam_dout = 4'h0;
    logic       cam_hit = 1'b0;
    logic [4:0] count;
    logic       init_done;
    state_e     dbg_state;

    cam_access_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req0_op     (req0_op),
        .req0_key    (req0_key),
        .req1_op     (req1_op),
        .req1_key    (req1_key),
        .rsp_valid   (rsp_valid),
        .rsp_id      (rsp_id),
        .rsp_hit     (rsp_hit),
        .rsp_index   (rsp_index),
        .rsp_err     (rsp_err),
        .cam_wen     (cam_wen),
        .cam_ren     (cam_ren),
        .cam_din     (cam_din),
        .cam_addr    (cam_addr),
        .cam_dout    (cam_dout),
        .cam_hit     (cam_hit),
        .count       (count),
        .init_done   (init_done),
        .dbg_state_o (dbg_state)
    );

    // ---------------- behavioural CAM (registered search) ----------------
    logic [7:0] cam_mem [16];
    initial for (int i = 0; i < 16; i++) cam_mem[i] = 8'h00;

    always @(posedge clk) begin
        if (cam_wen) cam_mem[cam_addr] <= cam_din;
        cam_hit  <= 1'b0;
        cam_dout <= 4'h0;
        if (cam_ren) begin
            for (int i = 15; i >= 0; i--) begin
                if (cam_mem[i] == cam_din) begin
                    cam_hit  <= 1'b1;
                    cam_dout <= 4'(i);
                end
            end
        end
    end

    // ---------------- scoreboard ----------------
    int n_vec  = 0;
    int n_fail = 0;
    logic [31:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- driver ----------------
    logic       r_got, r_id, r_hit, r_err, r_wen_seen, r_ren_seen, r_acc;
    logic [3:0] r_idx;
    logic [4:0] r_cnt;
    int         r_lat;

    task automatic drive_req(input logic id, input logic [1:0] op, input logic [7:0] key);
        req_valid[id] = 1'b1;
        if (id) begin req1_op = op; req1_key = key; end
        else    begin req0_op = op; req0_key = key; end
    endtask

    // Issues one command; returns latency (negedges after the accept cycle
    // T0) and captured response fields.
    task automatic run_cmd(input logic id, input logic [1:0] op, input logic [7:0] key);
        int n;
        r_got = 0; r_acc = 0; r_lat = 0; r_wen_seen = 0; r_ren_seen = 0;
        r_id = 0; r_hit = 0; r_err = 0; r_idx = 0; r_cnt = 0;
        @(negedge clk);
        drive_req(id, op, key);
        #1;
        n = 0;
        while (!req_ready[id] && n < 50) begin
            @(negedge clk); #1; n++;
        end
        if (!req_ready[id]) begin
            req_valid[id] = 1'b0;
            return;
        end
        r_acc = 1;
        for (int t = 1; t <= 8 && !r_got; t++) begin
            @(negedge clk);
            if (t == 1) req_valid[id] = 1'b0;
            r_wen_seen |= cam_wen;
            r_ren_seen |= cam_ren;
            if (rsp_valid) begin
                r_got = 1; r_lat = t;
                r_id = rsp_id; r_hit = rsp_hit; r_err = rsp_err;
                r_idx = rsp_index; r_cnt = count;
            end
        end
    endtask

    task automatic check_sweep(input string tag);
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            chk($sformatf("%s_wen_c%0d", tag, k), cam_wen, 1);
            chk($sformatf("%s_addr_c%0d", tag, k), cam_addr, k - 1);
            chk($sformatf("%s_din_c%0d", tag, k), cam_din, 8'hFF);
            chk($sformatf("%s_ready_c%0d", tag, k), req_ready, 2'b00);
            chk($sformatf("%s_idone_c%0d", tag, k), init_done, 0);
        end
        req_valid = 2'b00;
        @(negedge clk);
        chk({tag, "_idone_c17"}, init_done, 1);
        chk({tag, "_wen_c17"}, cam_wen, 0);
        chk({tag, "_count_c17"}, count, 0);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_req_ready"}, req_ready, 0);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_rsp_id"}, rsp_id, 0);
        chk({tag, "_rsp_hit"}, rsp_hit, 0);
        chk({tag, "_rsp_index"}, rsp_index, 0);
        chk({tag, "_rsp_err"}, rsp_err, 0);
        chk({tag, "_cam_wen"}, cam_wen, 0);
        chk({tag, "_cam_ren"}, cam_ren, 0);
        chk({tag, "_cam_din"}, cam_din, 0);
        chk({tag, "_cam_addr"}, cam_addr, 0);
        chk({tag, "_count"}, count, 0);
        chk({tag, "_init_done"}, init_done, 0);
        chk({tag, "_state"}, dbg_state, ST_INIT);
    endtask

    // ---------------- vector table ----------------
    typedef struct packed {
        logic       id;
        logic [1:0] op;
        logic [7:0] key;
        logic       hit;
        logic [3:0] idx;
        logic       err;
        logic [3:0] lat;
        logic [4:0] cnt;
        logic       wen;
        logic       ren;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic id, logic [1:0] op, logic [7:0] key, logic hit,
                                logic [3:0] idx, logic err, logic [3:0] lat,
                                logic [4:0] cnt, logic wen, logic ren);
        vec_t v;
        v.id = id; v.op = op; v.key = key; v.hit = hit; v.idx = idx; v.err = err;
        v.lat = lat; v.cnt = cnt; v.wen = wen; v.ren = ren;
        return v;
    endfunction

    // ---------------- main test ----------------
    initial begin
        int got_n;
        vec_t v;

        vecs.push_back(mk(0, OP_INSERT, 8'h3C, 0, 4'd0, 0, 4, 5'd1, 1, 1));
        vecs.push_back(mk(1, OP_LOOKUP, 8'h3C, 1, 4'd0, 0, 3, 5'd1, 0, 1));
        for (int i = 0; i < 15; i++)
            vecs.push_back(mk(0, OP_INSERT, 8'(8'h10 + i), 0, 4'(i + 1), 0, 4, 5'(i + 2), 1, 1));
        vecs.push_back(mk(0, OP_INSERT, 8'h40, 0, 4'd0, 1, 3, 5'd16, 0, 1));  // CAM full
        vecs.push_back(mk(1, OP_DELETE, 8'h14, 1, 4'd5, 0, 4, 5'd15, 1, 1));
        vecs.push_back(mk(0, OP_INSERT, 8'h50, 0, 4'd5, 0, 4, 5'd16, 1, 1));  // reuses slot 5
        vecs.push_back(mk(1, OP_LOOKUP, 8'h14, 0, 4'd0, 0, 3, 5'd16, 0, 1));
        vecs.push_back(mk(0, OP_LOOKUP, 8'hFF, 0, 4'd0, 1, 1, 5'd16, 0, 0));  // reserved key
        vecs.push_back(mk(1, 2'b11,     8'h01, 0, 4'd0, 1, 1, 5'd16, 0, 0));  // reserved op
        vecs.push_back(mk(0, OP_INSERT, 8'h3C, 1, 4'd0, 0, 3, 5'd16, 0, 1));  // insert hit
        vecs.push_back(mk(0, OP_DELETE, 8'h77, 0, 4'd0, 0, 3, 5'd16, 0, 1));  // delete miss
        vecs.push_back(mk(1, OP_LOOKUP, 8'h50, 1, 4'd5, 0, 3, 5'd16, 0, 1));

        // Reset state, then the clearing sweep with both requesters asking.
        #1;
        check_reset_vals("rst");
        repeat (2) @(negedge clk);
        req_valid = 2'b11;
        rst_n = 1'b1;
        check_sweep("sweep");

        foreach (vecs[k]) begin
            v = vecs[k];
            run_cmd(v.id, v.op, v.key);
            chk($sformatf("v%0d_accept", k), r_acc, 1);
            chk($sformatf("v%0d_rsp_seen", k), r_got, 1);
            chk($sformatf("v%0d_lat", k), r_lat, v.lat);
            chk($sformatf("v%0d_id", k), r_id, v.id);
            chk($sformatf("v%0d_hit", k), r_hit, v.hit);
            chk($sformatf("v%0d_idx", k), r_idx, v.idx);
            chk($sformatf("v%0d_err", k), r_err, v.err);
            chk($sformatf("v%0d_count", k), r_cnt, v.cnt);
            chk($sformatf("v%0d_wen", k), r_wen_seen, v.wen);
            chk($sformatf("v%0d_ren", k), r_ren_seen, v.ren);
        end

        // Both requesters hold valid: grants alternate starting with 0.
        exp_q = '{0, 1, 0, 1};
        @(negedge clk);
        req0_op = OP_LOOKUP; req0_key = 8'h3C;
        req1_op = OP_LOOKUP; req1_key = 8'h50;
        req_valid = 2'b11;
        got_n = 0;
        for (int t = 0; t < 60 && got_n < 4; t++) begin
            @(negedge clk);
            if (rsp_valid) begin
                chk($sformatf("rr_id%0d", got_n), rsp_id, exp_q.pop_front());
                chk($sformatf("rr_hit%0d", got_n), rsp_hit, 1);
                got_n++;
            end
        end
        req_valid = 2'b00;
        chk("rr_rsp_count", got_n, 4);

        // Reset pulsed during WRITE of a delete-hit.
        run_cmd_partial();
        repeat (3) begin
            @(negedge clk);
            chk("rstw_no_rsp", rsp_valid, 0);
        end
        rst_n = 1'b1;
        check_sweep("resweep");

        // Occupancy cleared by reset: first insert lands in slot 0 again.
        run_cmd(1, OP_INSERT, 8'h3C);
        chk("post_rst_rsp_seen", r_got, 1);
        chk("post_rst_lat", r_lat, 4);
        chk("post_rst_hit", r_hit, 0);
        chk("post_rst_idx", r_idx, 0);
        chk("post_rst_count", r_cnt, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    task automatic run_cmd_partial();
        int n;
        @(negedge clk);
        drive_req(0, OP_DELETE, 8'h50);
        #1;
        n = 0;
        while (!req_ready[0] && n < 50) begin
            @(negedge clk); #1; n++;
        end
        chk("rstw_accept", req_ready[0], 1);
        repeat (3) @(negedge clk);   // T1, T2, T3
        req_valid = 2'b00;
        chk("rstw_in_write", cam_wen, 1);
        rst_n = 1'b0;
        #1;
        check_reset_vals("rstw");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cam_access_ctrl.md
# cam_access_ctrl

Controller that owns the 16×8 content-addressable memory and shares it between two requesters. It runs a post-reset clearing sweep, serializes lookup/insert/delete commands with round-robin arbitration, and tracks entry occupancy and free-slot allocation. It sequences the CAM's wen/ren/din/addr pins and returns one response per accepted command.

## Interface
Parameters:
- `ENTRIES`, 16: CAM depth (fixed; matches CAM).
- `KEY_W`, 8: key width.
- `IDX_W`, 4: index width.
- `EMPTY_KEY`, 8'hFF: marker written into free entries; reserved, never a legal key.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_valid` in 2: per-requester command valid; held until accepted.
- `req_ready` out 2: per-requester accept; transfer when valid&ready.
- `req0_op`, `req1_op` in 2: command op. 00 lookup, 01 insert, 10 delete, 11 reserved (error).
- `req0_key`, `req1_key` in KEY_W: command key.
- `rsp_valid` out 1: one-cycle response pulse; no backpressure.
- `rsp_id` out 1: requester that issued the command.
- `rsp_hit` out 1: key was present before the command.
- `rsp_index` out IDX_W: matched index, or allocated index on insert miss.
- `rsp_err` out 1: reserved op, key==EMPTY_KEY, or insert into a full CAM.
- `cam_wen`, `cam_ren` out 1: CAM write/search enables; never both 1.
- `cam_din` out KEY_W: CAM data/search key.
- `cam_addr` out IDX_W: CAM write address.
- `cam_dout` in IDX_W: CAM matched index (registered by CAM).
- `cam_hit` in 1: CAM match flag (registered by CAM).
- `count` out 5: number of valid entries, 0..16.
- `init_done` out 1: clearing sweep complete.

## Operation
- States: INIT, IDLE, LOOKUP, CHECK, WRITE, RESP.
- INIT: drive cam_wen=1, cam_din=EMPTY_KEY, cam_addr=sweep counter 0..15. Runs 16 cycles, then IDLE with init_done=1. req_ready=0 throughout.
- IDLE:
  - cam_wen=0 and cam_ren=0. This guarantees cam_hit reads 0 before every search.
  - Grant goes to the only valid requester. If both are valid, grant the one not granted last; after reset, requester 0 is favored.
  - req_ready[grant]=1 only in IDLE. On accept, latch id, op, and key.
- After accept:
  - Reserved op or key==EMPTY_KEY: go straight to RESP with err=1, hit=0, index=0.
  - Otherwise go to LOOKUP.
- LOOKUP: cam_ren=1, cam_din=key, for one cycle.
- CHECK: sample cam_hit and cam_dout.
  - Lookup: go to RESP.
  - Insert hit: RESP with the existing index; no write.
  - Insert miss with a free slot: slot = lowest index with valid=0. Go to WRITE with key, then set valid[slot] and increment count.
  - Insert miss with CAM full (count==16): RESP with err=1, index=0.
  - Delete hit: WRITE EMPTY_KEY at cam_dout, clear valid, decrement count.
  - Delete miss: RESP with hit=0.
- WRITE: cam_wen=1 for one cycle, then RESP.
- RESP: rsp_valid=1 for one cycle with registered fields, then IDLE.
- valid[15:0] and count update on the WRITE-cycle edge.

## Timing
- Handshake cycle = T0.
- Lookup, or any command without a write: rsp_valid in T3.
- Insert-allocate or delete-hit: rsp_valid in T4.
- Error commands: rsp_valid in T1.
- Throughput: one command in flight; next accept earliest in the cycle after RESP.
- Reset values: req_ready=0, rsp_valid=0, rsp_id=0, rsp_hit=0, rsp_index=0, rsp_err=0, cam_wen=0, cam_ren=0, cam_din=0, cam_addr=0, count=0, init_done=0, valid=0, round-robin pointer favors requester 0.
- rst_n asserted mid-command:
  - The command is dropped with no response.
  - The block re-enters INIT and re-sweeps after rst_n releases.
- Outputs rsp_*, cam_*, count, and init_done are registered. req_ready is combinational from state, grant pointer, and req_valid.

## Structure
- Shared package `cam_ctrl_pkg` holds:
  - op encodings OP_LOOKUP, OP_INSERT, OP_DELETE;
  - EMPTY_KEY, ENTRIES, KEY_W, IDX_W;
  - the state enum.
- Sub-module `cam_free_enc`: lowest-zero priority encoder over valid[15:0]. Outputs free_idx[3:0] and full.
- The top level instantiates `cam_free_enc` plus the FSM, arbiter, and valid/count registers. The CAM itself sits outside, at the parent level.

## Test plan
- Reset release:
  - cam_wen high for 16 cycles with addr 0..15 and din 8'hFF.
  - init_done rises in cycle 17.
  - req_ready stays 0 during the sweep.
- Insert key 8'h3C from req0, then lookup 8'h3C from req1:
  - Insert: rsp_hit=0, rsp_index=0, count=1, rsp_valid at T4.
  - Lookup: rsp_hit=1, rsp_index=0, rsp_id=1, rsp_valid at T3.
- Insert 16 distinct keys, then a 17th:
  - Indices 0..15 are allocated in order.
  - 17th: rsp_err=1 with no cam_wen pulse, and count stays 16.
- Delete at index 5, then insert a new key:
  - Delete: rsp_hit=1, count drops by 1.
  - New key is allocated to index 5.
  - A lookup of the deleted key returns rsp_hit=0.
- Both requesters hold valid continuously:
  - Grants alternate 0,1,0,1.
  - rsp_id follows the same order; neither requester starves.
- Edge cases:
  - A key of 8'hFF gives rsp_err=1 at T1 with no CAM access.
  - rst_n pulsed during WRITE: all outputs return to reset values, no response is issued, and INIT restarts.
